pc_redirect_ctrl: RTL and testbench
===================================

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 9: width of the fetch PC.
REQ-002 SHALL have parameter RESET_PC, default 0: PC value loaded on reset, PC_W bits.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port stall, input, 1: hazard-unit hold request; freezes sequential fetch.
REQ-006 SHALL have port imem_ready, input, 1: instruction memory accepts the current PC this cycle.
REQ-007 SHALL have port ex_valid, input, 1: the EX-stage instruction is valid (not a bubble).
REQ-008 SHALL have port pc_sel, input, 1: branch-unit redirect select for the EX instruction.
REQ-009 SHALL have port branch_target, input, 32: branch-unit redirect target.
REQ-010 SHALL have port pc, output, PC_W: registered fetch PC.
REQ-011 SHALL have port fetch_valid, output, 1: the instruction fetched at pc this cycle is valid.
REQ-012 SHALL have port if_id_flush, output, 1: clear the IF/ID register at the next edge.
REQ-013 SHALL have port id_ex_flush, output, 1: clear the ID/EX register at the next edge.
REQ-014 SHALL have port redirect_pending, output, 1: high while in state PEND.
REQ-015 SHALL have port taken_count, output, 16: saturating count of redirects.
REQ-016 SHALL have port misalign_err, output, 1: sticky flag for a target with bits [1:0] nonzero.

Function
REQ-017 SHALL define redirect event R = ex_valid AND pc_sel, evaluated combinationally each cycle.
REQ-018 SHALL implement the FSM states RUN and PEND; PEND holds a latched target tgt_q of PC_W bits.
REQ-019 SHALL form the effective target as branch_target[PC_W-1:0] with bits [1:0] forced to 0.
REQ-020 SHALL, in RUN with R=1 and imem_ready=1, load pc with the effective target and remain in RUN.
REQ-021 SHALL, in RUN with R=1 and imem_ready=0, latch the effective target into tgt_q, hold pc and go to PEND.
REQ-022 SHALL, in RUN with R=0, imem_ready=1 and stall=0, advance pc by 4 modulo 2^PC_W (wrap, no flag).
REQ-023 SHALL, in RUN with R=0 and either stall=1 or imem_ready=0, hold pc.
REQ-024 SHALL give redirect priority over stall: R=1 with stall=1 behaves as R=1 with stall=0.
REQ-025 SHALL, in PEND, hold pc; when imem_ready=1, load pc with tgt_q and return to RUN.
REQ-026 SHALL, in PEND with R=1, overwrite tgt_q with the new effective target, where the newest redirect wins even if imem_ready=1 in that cycle.
REQ-027 SHALL drive if_id_flush = R OR (state==PEND), and id_ex_flush = R, combinationally.
REQ-028 SHALL drive fetch_valid = (state==RUN) AND imem_ready AND NOT stall AND NOT R.
REQ-029 SHALL increment taken_count by 1 on every cycle with R=1, saturating at 0xFFFF.
REQ-030 SHALL set misalign_err on any cycle with R=1 and branch_target[1:0]!=0; it is cleared only by reset.
REQ-031 SHALL have a latency of exactly one clock edge from a redirect being accepted to the new pc.

Reset
REQ-032 SHALL, while reset=0, asynchronously force pc=RESET_PC, state=RUN, tgt_q=0, taken_count=0 and misalign_err=0.
REQ-033 SHALL drive the combinational outputs from the reset state while in reset: redirect_pending=0, with fetch_valid and flushes following inputs per REQ-027/028.
REQ-034 SHALL abandon a redirect held in PEND when reset is asserted mid-operation; after release, pc=RESET_PC and the FSM is in RUN.

Verification
REQ-035 SHALL be covered by sequential fetch: reset release, imem_ready=1, 3 cycles -> pc 0,4,8,12; fetch_valid=1 throughout.
REQ-036 SHALL be covered by a redirect taken with stall=1: pc=0x10, R=1, target=0x40, stall=1 -> if_id_flush=1, id_ex_flush=1, next pc=0x40, taken_count=1.
REQ-037 SHALL be covered by a pending redirect: R=1, target=0x80, imem_ready=0 for 3 cycles -> redirect_pending=1, pc held, if_id_flush=1; imem_ready=1 -> next pc=0x80, state RUN.
REQ-038 SHALL be covered by wrap and truncation: pc=0x1FC (PC_W=9) advances to 0x000; target=0x00000244 loads pc=0x044.
REQ-039 SHALL be covered by misalignment: target=0x42 with R=1 -> pc=0x40, misalign_err=1, and misalign_err stays 1 until reset.
REQ-040 SHALL be covered by saturation and reset in PEND: taken_count preset at 0xFFFF with R=1 -> stays 0xFFFF; reset asserted in PEND -> pc=RESET_PC, redirect_pending=0, taken_count=0.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// Purpose: fetch PC sequencer with branch redirect, pending-redirect hold and flush generation.
// Latency: an accepted redirect appears on pc one clock edge later; sequential advance is +4 per edge.
// Backpressure: imem_ready low or stall high holds pc; a redirect arriving while imem is not ready is parked in PEND.
module pc_redirect_ctrl #(
  parameter int unsigned           PC_W     = 9,
  parameter logic [PC_W-1:0]       RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            imem_ready,
  input  logic            ex_valid,
  input  logic            pc_sel,
  input  logic [31:0]     branch_target,
  output logic [PC_W-1:0] pc,
  output logic            fetch_valid,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic            redirect_pending,
  output logic [15:0]     taken_count,
  output logic            misalign_err
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            mis_q, mis_d;

  logic            redir;
  logic [PC_W-1:0] eff_tgt;
  logic [PC_W-1:0] pc_inc;

  // Redirect event, word-aligned truncated target and sequential next PC.
  always_comb begin
    redir   = ex_valid & pc_sel;
    eff_tgt = {branch_target[PC_W-1:2], 2'b00};
    pc_inc  = pc_q + PC_W'(4);
  end

  // Next-state logic: redirect beats stall; the newest redirect always owns the parked target.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    case (state_q)
      RUN: begin
        if (redir) begin
          if (imem_ready) begin
            pc_d = eff_tgt;
          end else begin
            tgt_d   = eff_tgt;
            state_d = PEND;
          end
        end else if (imem_ready && !stall) begin
          pc_d = pc_inc;
        end
      end
      PEND: begin
        if (redir) begin
          // A younger redirect replaces the parked one; it is issued on a later ready cycle.
          tgt_d = eff_tgt;
        end else if (imem_ready) begin
          pc_d    = tgt_q;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Saturating redirect counter and sticky misaligned-target flag.
  always_comb begin
    cnt_d = cnt_q;
    mis_d = mis_q;
    if (redir) begin
      if (cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end
      if (branch_target[1:0] != 2'b00) begin
        mis_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset; a parked redirect is dropped on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  // Combinational outputs derived from current state and inputs.
  always_comb begin
    pc               = pc_q;
    redirect_pending = (state_q == PEND);
    if_id_flush      = redir | (state_q == PEND);
    id_ex_flush      = redir;
    fetch_valid      = (state_q == RUN) & imem_ready & ~stall & ~redir;
    taken_count      = cnt_q;
    misalign_err     = mis_q;
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
module tb_pc_redirect_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        imem_ready;
  logic        ex_valid;
  logic        pc_sel;
  logic [31:0] branch_target;
  logic [8:0]  pc;
  logic        fetch_valid;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        redirect_pending;
  logic [15:0] taken_count;
  logic        misalign_err;

  int checks;
  int failures;

  pc_redirect_ctrl #(.PC_W(9), .RESET_PC(9'h000)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .imem_ready       (imem_ready),
    .ex_valid         (ex_valid),
    .pc_sel           (pc_sel),
    .branch_target    (branch_target),
    .pc               (pc),
    .fetch_valid      (fetch_valid),
    .if_id_flush      (if_id_flush),
    .id_ex_flush      (id_ex_flush),
    .redirect_pending (redirect_pending),
    .taken_count      (taken_count),
    .misalign_err     (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        rdy;
    logic        ev;
    logic        ps;
    logic [31:0] tgt;
    logic [8:0]  pc;
    logic        fv;
    logic        ifid;
    logic        idex;
    logic        pend;
    logic [15:0] cnt;
    logic        mis;
  } vec_t;

  localparam int NV = 26;
  vec_t vt[NV];

  function automatic vec_t mk(input logic st, input logic rdy, input logic ev, input logic ps,
                              input logic [31:0] tgt, input logic [8:0] epc, input logic fv,
                              input logic ifid, input logic idex, input logic pend,
                              input logic [15:0] cnt, input logic mis);
    vec_t v;
    v.st = st; v.rdy = rdy; v.ev = ev; v.ps = ps; v.tgt = tgt;
    v.pc = epc; v.fv = fv; v.ifid = ifid; v.idex = idex; v.pend = pend;
    v.cnt = cnt; v.mis = mis;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic rdy, input logic ev, input logic ps,
                       input logic [31:0] tgt);
    stall = st; imem_ready = rdy; ex_valid = ev; pc_sel = ps; branch_target = tgt;
  endtask

  initial begin
    checks = 0;
    failures = 0;

    //          st rdy ev ps tgt           pc      fv ifid idex pend cnt  mis
    vt[0]  = mk(0, 1, 0, 0, 32'h0,       9'h000, 1, 0, 0, 0, 16'd0, 0);
    vt[1]  = mk(0, 1, 0, 0, 32'h0,       9'h004, 1, 0, 0, 0, 16'd0, 0);
    vt[2]  = mk(0, 1, 0, 0, 32'h0,       9'h008, 1, 0, 0, 0, 16'd0, 0);
    vt[3]  = mk(0, 1, 0, 0, 32'h0,       9'h00C, 1, 0, 0, 0, 16'd0, 0);
    vt[4]  = mk(1, 1, 0, 0, 32'h0,       9'h010, 0, 0, 0, 0, 16'd0, 0);
    vt[5]  = mk(1, 1, 1, 1, 32'h40,      9'h010, 0, 1, 1, 0, 16'd0, 0);
    vt[6]  = mk(0, 1, 0, 0, 32'h0,       9'h040, 1, 0, 0, 0, 16'd1, 0);
    vt[7]  = mk(0, 1, 1, 0, 32'h100,     9'h044, 1, 0, 0, 0, 16'd1, 0);
    vt[8]  = mk(0, 1, 0, 1, 32'h100,     9'h048, 1, 0, 0, 0, 16'd1, 0);
    vt[9]  = mk(0, 0, 1, 1, 32'h80,      9'h04C, 0, 1, 1, 0, 16'd1, 0);
    vt[10] = mk(0, 0, 0, 0, 32'h0,       9'h04C, 0, 1, 0, 1, 16'd2, 0);
    vt[11] = mk(0, 0, 0, 0, 32'h0,       9'h04C, 0, 1, 0, 1, 16'd2, 0);
    vt[12] = mk(0, 1, 0, 0, 32'h0,       9'h04C, 0, 1, 0, 1, 16'd2, 0);
    vt[13] = mk(0, 1, 0, 0, 32'h0,       9'h080, 1, 0, 0, 0, 16'd2, 0);
    vt[14] = mk(0, 1, 1, 1, 32'h42,      9'h084, 0, 1, 1, 0, 16'd2, 0);
    vt[15] = mk(0, 0, 0, 0, 32'h0,       9'h040, 0, 0, 0, 0, 16'd3, 1);
    vt[16] = mk(0, 1, 1, 1, 32'h244,     9'h040, 0, 1, 1, 0, 16'd3, 1);
    vt[17] = mk(0, 1, 0, 0, 32'h0,       9'h044, 1, 0, 0, 0, 16'd4, 1);
    vt[18] = mk(0, 1, 1, 1, 32'h1F8,     9'h048, 0, 1, 1, 0, 16'd4, 1);
    vt[19] = mk(0, 1, 0, 0, 32'h0,       9'h1F8, 1, 0, 0, 0, 16'd5, 1);
    vt[20] = mk(0, 1, 0, 0, 32'h0,       9'h1FC, 1, 0, 0, 0, 16'd5, 1);
    vt[21] = mk(0, 1, 0, 0, 32'h0,       9'h000, 1, 0, 0, 0, 16'd5, 1);
    vt[22] = mk(0, 0, 1, 1, 32'h100,     9'h004, 0, 1, 1, 0, 16'd5, 1);
    vt[23] = mk(0, 0, 1, 1, 32'h120,     9'h004, 0, 1, 1, 1, 16'd6, 1);
    vt[24] = mk(0, 1, 0, 0, 32'h0,       9'h004, 0, 1, 0, 1, 16'd7, 1);
    vt[25] = mk(0, 1, 0, 0, 32'h0,       9'h120, 1, 0, 0, 0, 16'd7, 1);

    // Reset state, with combinational outputs following inputs.
    reset = 1'b0;
    drive(0, 1, 1, 1, 32'h40);
    #12;
    chk("rst_pc", 32'(pc), 32'h000);
    chk("rst_pend", 32'(redirect_pending), 32'h0);
    chk("rst_cnt", 32'(taken_count), 32'h0);
    chk("rst_mis", 32'(misalign_err), 32'h0);
    chk("rst_ifid_r", 32'(if_id_flush), 32'h1);
    chk("rst_idex_r", 32'(id_ex_flush), 32'h1);
    chk("rst_fv_r", 32'(fetch_valid), 32'h0);
    drive(0, 1, 0, 0, 32'h0);
    #1;
    chk("rst_fv", 32'(fetch_valid), 32'h1);
    chk("rst_ifid", 32'(if_id_flush), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven vectors: inputs applied at negedge, outputs checked 1 time unit later.
    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      drive(vt[i].st, vt[i].rdy, vt[i].ev, vt[i].ps, vt[i].tgt);
      #1;
      chk($sformatf("v%0d_pc", i),   32'(pc),               32'(vt[i].pc));
      chk($sformatf("v%0d_fv", i),   32'(fetch_valid),      32'(vt[i].fv));
      chk($sformatf("v%0d_ifid", i), 32'(if_id_flush),      32'(vt[i].ifid));
      chk($sformatf("v%0d_idex", i), 32'(id_ex_flush),      32'(vt[i].idex));
      chk($sformatf("v%0d_pend", i), 32'(redirect_pending), 32'(vt[i].pend));
      chk($sformatf("v%0d_cnt", i),  32'(taken_count),      32'(vt[i].cnt));
      chk($sformatf("v%0d_mis", i),  32'(misalign_err),     32'(vt[i].mis));
    end

    // Reset asserted while a redirect is parked in PEND: the redirect is abandoned.
    @(negedge clk);
    drive(0, 0, 1, 1, 32'h80);
    @(negedge clk);
    drive(0, 0, 0, 0, 32'h0);
    #1;
    chk("pend_before_rst", 32'(redirect_pending), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("pend_rst_pc", 32'(pc), 32'h000);
    chk("pend_rst_pend", 32'(redirect_pending), 32'h0);
    chk("pend_rst_cnt", 32'(taken_count), 32'h0);
    chk("pend_rst_mis", 32'(misalign_err), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 1, 0, 0, 32'h0);
    #1;
    chk("post_rst_pc0", 32'(pc), 32'h000);
    chk("post_rst_fv", 32'(fetch_valid), 32'h1);
    @(negedge clk);
    #1;
    chk("post_rst_pc1", 32'(pc), 32'h004);
    chk("post_rst_pend", 32'(redirect_pending), 32'h0);

    // Saturation: 65535 redirects reach 0xFFFF, further redirects keep it there.
    @(negedge clk);
    drive(0, 1, 1, 1, 32'h40);
    for (int n = 0; n < 65535; n++) @(negedge clk);
    #1;
    chk("sat_reach", 32'(taken_count), 32'hFFFF);
    chk("sat_pc", 32'(pc), 32'h040);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("sat_hold", 32'(taken_count), 32'hFFFF);
    chk("sat_mis", 32'(misalign_err), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
